// File: rtl/spare_allocation_scheduler.sv
// Walks the candidate repair space (pivot row/col split, then local spare selection) for one
// BIRA run, driving the analyzer and stopping at the first candidate that covers every fault.
module spare_allocation_scheduler #(
    parameter int PCAM       = 8,
    parameter int NPCAM      = 30,
    parameter int RLSS_W     = 4,
    parameter int ROW_SPARES = 2,
    parameter int COL_SPARES = 2,
    parameter int ANA_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PCAM-1:0]   pivot_valid,
    input  logic [NPCAM-1:0]  nonpivot_valid,
    input  logic [NPCAM-1:0]  nonpivot_cover_result,
    output logic [PCAM-1:0]   dsss,
    output logic [RLSS_W-1:0] rlss,
    output logic              busy,
    output logic              done,
    output logic              repairable,
    output logic [PCAM-1:0]   dsss_sol,
    output logic [RLSS_W-1:0] rlss_sol,
    output logic [15:0]       try_cnt
);

    localparam int CNT_W = (ANA_LAT < 2) ? 1 : $clog2(ANA_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRECHK, ST_APPLY, ST_WAIT, ST_CHECK, ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [PCAM-1:0]    dsss_reg, dsss_next;
    logic [RLSS_W-1:0]  rlss_reg, rlss_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               repairable_reg, repairable_next;
    logic [PCAM-1:0]    dsss_sol_reg, dsss_sol_next;
    logic [RLSS_W-1:0]  rlss_sol_reg, rlss_sol_next;
    logic [15:0]        try_cnt_reg, try_cnt_next;
    logic [PCAM-1:0]    pv_reg, pv_next;
    logic [NPCAM-1:0]   npv_reg, npv_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;

    logic [NPCAM-1:0]   cover_bit;
    logic               covered;
    logic               dsss_legal;
    logic               too_many_pivots;

    // An invalid non-pivot entry never needs covering.
    for (genvar gi = 0; gi < NPCAM; gi++) begin : g_cover
        assign cover_bit[gi] = nonpivot_cover_result[gi] | ~npv_reg[gi];
    end
    assign covered = &cover_bit;

    assign dsss_legal = ((dsss_reg & ~pv_reg) == '0)
                     && ($countones(dsss_reg) <= ROW_SPARES)
                     && ($countones(pv_reg & ~dsss_reg) <= COL_SPARES);
    assign too_many_pivots = $countones(pv_reg) > (ROW_SPARES + COL_SPARES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            dsss_reg       <= '0;
            rlss_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            repairable_reg <= 1'b0;
            dsss_sol_reg   <= '0;
            rlss_sol_reg   <= '0;
            try_cnt_reg    <= '0;
            pv_reg         <= '0;
            npv_reg        <= '0;
            wait_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            dsss_reg       <= dsss_next;
            rlss_reg       <= rlss_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            repairable_reg <= repairable_next;
            dsss_sol_reg   <= dsss_sol_next;
            rlss_sol_reg   <= rlss_sol_next;
            try_cnt_reg    <= try_cnt_next;
            pv_reg         <= pv_next;
            npv_reg        <= npv_next;
            wait_cnt_reg   <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        dsss_next       = dsss_reg;
        rlss_next       = rlss_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        repairable_next = repairable_reg;
        dsss_sol_next   = dsss_sol_reg;
        rlss_sol_next   = rlss_sol_reg;
        try_cnt_next    = try_cnt_reg;
        pv_next         = pv_reg;
        npv_next        = npv_reg;
        wait_cnt_next   = wait_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pv_next         = pivot_valid;
                    npv_next        = nonpivot_valid;
                    dsss_next       = '0;
                    rlss_next       = '0;
                    try_cnt_next    = '0;
                    repairable_next = 1'b0;
                    busy_next       = 1'b1;
                    state_next      = ST_PRECHK;
                end
            end
            ST_PRECHK: begin
                if (too_many_pivots) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (dsss_legal) begin
                    wait_cnt_next = CNT_W'(ANA_LAT);
                    state_next    = ST_WAIT;
                end else if (&dsss_reg) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    dsss_next = dsss_reg + PCAM'(1);
                    rlss_next = '0;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - CNT_W'(1);
                if (wait_cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (try_cnt_reg != 16'hFFFF) begin
                    try_cnt_next = try_cnt_reg + 16'd1;
                end
                if (covered) begin
                    dsss_sol_next   = dsss_reg;
                    rlss_sol_next   = rlss_reg;
                    repairable_next = 1'b1;
                    done_next       = 1'b1;
                    state_next      = ST_DONE;
                end else if (!(&rlss_reg)) begin
                    rlss_next  = rlss_reg + RLSS_W'(1);
                    state_next = ST_APPLY;
                end else begin
                    rlss_next = '0;
                    if (&dsss_reg) begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        dsss_next  = dsss_reg + PCAM'(1);
                        state_next = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort discards the run entirely, including any result about to be published.
        if (abort && state_reg != ST_IDLE) begin
            state_next      = ST_IDLE;
            busy_next       = 1'b0;
            done_next       = 1'b0;
            repairable_next = 1'b0;
            dsss_next       = dsss_reg;
            rlss_next       = rlss_reg;
            try_cnt_next    = try_cnt_reg;
            dsss_sol_next   = dsss_sol_reg;
            rlss_sol_next   = rlss_sol_reg;
        end
    end

    assign dsss       = dsss_reg;
    assign rlss       = rlss_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign repairable = repairable_reg;
    assign dsss_sol   = dsss_sol_reg;
    assign rlss_sol   = rlss_sol_reg;
    assign try_cnt    = try_cnt_reg;

endmodule

// File: tb/tb_spare_allocation_scheduler.sv
// Scoreboard bench: a candidate-enumeration reference model predicts each run's result and
// completion cycle; a monitor pops and compares whenever done pulses.
module tb_spare_allocation_scheduler;

    localparam int PCAM    = 8;
    localparam int NPCAM   = 30;
    localparam int RLSS_W  = 4;
    localparam int ROW_SP  = 2;
    localparam int COL_SP  = 2;
    localparam int ANA_LAT = 1;
    localparam int TIMEOUT = 4000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PCAM-1:0]   pivot_valid = '0;
    logic [NPCAM-1:0]  nonpivot_valid = '0;
    logic [NPCAM-1:0]  cover_q = '0;
    logic [PCAM-1:0]   dsss;
    logic [RLSS_W-1:0] rlss;
    logic              busy, done, repairable;
    logic [PCAM-1:0]   dsss_sol;
    logic [RLSS_W-1:0] rlss_sol;
    logic [15:0]       try_cnt;

    spare_allocation_scheduler #(
        .PCAM(PCAM), .NPCAM(NPCAM), .RLSS_W(RLSS_W),
        .ROW_SPARES(ROW_SP), .COL_SPARES(COL_SP), .ANA_LAT(ANA_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pivot_valid(pivot_valid), .nonpivot_valid(nonpivot_valid),
        .nonpivot_cover_result(cover_q),
        .dsss(dsss), .rlss(rlss), .busy(busy), .done(done), .repairable(repairable),
        .dsss_sol(dsss_sol), .rlss_sol(rlss_sol), .try_cnt(try_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Analyzer stand-in: per-candidate cover vectors, one cycle of latency.
    logic [NPCAM-1:0] tab [0:255][0:15];
    always @(posedge clk) cover_q <= tab[dsss][rlss];

    typedef struct {
        logic        rep;
        logic [7:0]  dsol;
        logic [3:0]  rsol;
        logic [15:0] tries;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_dsol = '0;
    logic [3:0] last_rsol = '0;
    int         checks = 0;
    int         passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // First-fit search over dsss codes in ascending order, rlss 0..15 for each legal code.
    function automatic exp_t model(input logic [7:0] pv, input logic [NPCAM-1:0] npv, input int k);
        exp_t e;
        int   skips;
        int   tries;
        bit   found;
        logic [7:0] dv;
        skips = 0;
        tries = 0;
        found = 1'b0;
        e.rep  = 1'b0;
        e.dsol = last_dsol;
        e.rsol = last_rsol;
        if ($countones(pv) <= ROW_SP + COL_SP) begin
            for (int d = 0; d < 256 && !found; d++) begin
                dv = 8'(d);
                if ((dv & ~pv) != 8'h00 || $countones(dv) > ROW_SP
                    || $countones(pv & ~dv) > COL_SP) begin
                    skips++;
                    continue;
                end
                for (int r = 0; r < 16 && !found; r++) begin
                    tries++;
                    if (&(tab[d][r] | ~npv)) begin
                        found  = 1'b1;
                        e.rep  = 1'b1;
                        e.dsol = dv;
                        e.rsol = 4'(r);
                    end
                end
            end
        end
        e.tries = 16'(tries);
        e.cyc   = k + 2 + skips + (2 + ANA_LAT) * tries;
        return e;
    endfunction

    task automatic fill_tab(input bit rnd);
        for (int d = 0; d < 256; d++)
            for (int r = 0; r < 16; r++)
                tab[d][r] = !rnd ? '0 : (($urandom_range(0, 39) == 0) ? '1 : NPCAM'($urandom));
    endtask

    // Called at a negedge; start is sampled by the following posedge.
    task automatic launch(input logic [7:0] pv, input logic [NPCAM-1:0] npv);
        exp_t e;
        e = model(pv, npv, cyc);
        exp_q.push_back(e);
        if (e.rep) begin
            last_dsol = e.dsol;
            last_rsol = e.rsol;
        end
        pivot_valid    = pv;
        nonpivot_valid = npv;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        pivot_valid    = 8'($urandom);
        nonpivot_valid = NPCAM'($urandom);
        $display("run pv=%h npv=%h exp_rep=%0d exp_dsol=%h exp_rsol=%h exp_tries=%0d",
                 pv, npv, e.rep, e.dsol, e.rsol, e.tries);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d, required idle", name, busy, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dsss"}, dsss, 0);
        chk({tag, "_rlss"}, rlss, 0);
        chk({tag, "_try_cnt"}, try_cnt, 0);
        chk({tag, "_repairable"}, repairable, 0);
        chk({tag, "_dsss_sol"}, dsss_sol, 0);
        chk({tag, "_rlss_sol"}, rlss_sol, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done=1 with no run outstanding, required 0");
            end else begin
                e = exp_q.pop_front();
                chk("repairable", repairable, e.rep);
                chk("dsss_sol", dsss_sol, e.dsol);
                chk("rlss_sol", rlss_sol, e.rsol);
                chk("try_cnt", try_cnt, e.tries);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", busy, 1);
                $display("done rep=%0d dsss_sol=%h rlss_sol=%h try_cnt=%0d cyc=%0d",
                         repairable, dsss_sol, rlss_sol, try_cnt, cyc);
            end
        end
    end

    initial begin : driver
        int         n;
        logic [7:0] pv;

        fill_tab(1'b0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nothing to cover: the first candidate wins.
        fill_tab(1'b1);
        launch(8'h03, '0);
        wait_idle("first_candidate");

        // Only (dsss=02, rlss=5) covers.
        fill_tab(1'b0);
        tab[2][5] = '1;
        launch(8'h03, 30'h2AAA5555);
        wait_idle("late_hit");

        // Five pivots exceed four spares.
        launch(8'h1F, 30'h0000FFFF);
        wait_idle("precheck_fail");

        // Never covered: exhaust every legal code.
        fill_tab(1'b0);
        launch(8'h03, 30'h00000001);
        wait_idle("exhaust");

        // Abort during WAIT of the third candidate, with a competing start in the same cycle.
        launch(8'h03, 30'h00000001);
        n = 0;
        while (try_cnt != 16'd2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_third", try_cnt, 2);
        @(negedge clk);
        abort       = 1'b1;
        start       = 1'b1;
        pivot_valid = 8'h1F;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_repairable", repairable, 0);
        chk("abort_dsss_sol", dsss_sol, last_dsol);
        chk("abort_rlss_sol", rlss_sol, last_rsol);
        repeat (3) @(negedge clk);
        chk("abort_still_idle", busy, 0);
        fill_tab(1'b1);
        launch(8'h03, '0);
        wait_idle("after_abort");

        // A second start mid-run must not restart or relatch the masks.
        fill_tab(1'b0);
        launch(8'h03, 30'h00000001);
        repeat (20) @(negedge clk);
        pivot_valid    = 8'h1F;
        nonpivot_valid = '0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart_ignored");

        // Reset mid-run returns everything to zero immediately.
        launch(8'h03, 30'h00000001);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        exp_q.delete();
        last_dsol = '0;
        last_rsol = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized runs.
        repeat (25) begin
            fill_tab(1'b1);
            pv = '0;
            repeat ($urandom_range(0, 5)) pv[$urandom_range(0, 7)] = 1'b1;
            launch(pv, ($urandom_range(0, 3) == 0) ? '0 : NPCAM'($urandom & $urandom));
            wait_idle("random");
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
